// File: rtl/mem_bus_lsu_pkg.sv
// mips_defs: shared ByteOp encodings, exception codes and LSU state encoding
package mips_defs;
  localparam logic [2:0] BYTEOP_W = 3'b000;
  localparam logic [2:0] BYTEOP_B = 3'b101;
  localparam logic [2:0] BYTEOP_H = 3'b110;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;
endpackage

// File: rtl/mem_bus_lsu_lane.sv
// store_lane_gen: byte enables, lane-replicated store data and misalign flag
module store_lane_gen
  import mips_defs::*;
(
  input  logic [2:0]  byte_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  byteen,
  output logic [31:0] wdata_lane,
  output logic        misalign
);
  always_comb begin
    byteen = byte_op == BYTEOP_B ? 4'b0001 << addr_lo :
             byte_op == BYTEOP_H ? (addr_lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_lane = byte_op == BYTEOP_B ? {4{wdata[7:0]}} :
                 byte_op == BYTEOP_H ? {2{wdata[15:0]}} : wdata;
    misalign = byte_op == BYTEOP_B ? 1'b0 : byte_op == BYTEOP_H ? addr_lo[0] : |addr_lo;
  end
endmodule

// File: rtl/mem_bus_lsu.sv
// mem_bus_lsu: M-stage load/store unit driving a valid/ready data bus with pipeline stall
module mem_bus_lsu
  import mips_defs::*;
#(
  parameter int         TIMEOUT  = 16,
  parameter logic [4:0] EXC_ADEL = mips_defs::EXC_ADEL,
  parameter logic [4:0] EXC_ADES = mips_defs::EXC_ADES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  ByteOp,
  output logic        stall,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic        ld_valid,
  output logic [31:0] ld_data,
  output logic [31:0] ld_addr,
  output logic [2:0]  ld_byteop
);
  state_t state, nxt;
  logic [15:0] cnt;
  logic we_r, to_r;
  logic [31:0] addr_r;
  logic [2:0] op_r;
  logic [3:0] be;
  logic [31:0] wl;
  logic mis, go, cap, tmo;
  store_lane_gen u_lane (
    .byte_op(ByteOp), .addr_lo(mem_addr[1:0]), .wdata(mem_wdata),
    .byteen(be), .wdata_lane(wl), .misalign(mis)
  );
  always_comb begin
    go = state == S_IDLE && mem_req && !mis;
    cap = !we_r && bus_rvalid && (state == S_RESP || (state == S_REQ && bus_ready));
    tmo = TIMEOUT != 0 && cnt == 16'(TIMEOUT - 1) &&
          ((state == S_REQ && !bus_ready) || (state == S_RESP && !cap));
    nxt = go ? S_REQ :
          state == S_DONE ? S_IDLE :
          (state == S_REQ && bus_ready && !we_r && !cap) ? S_RESP :
          ((state == S_REQ && bus_ready) || cap || tmo) ? S_DONE : state;
    // combinational outputs are gated by reset so an asserted reset forces them low at once
    stall = reset && (go || state == S_REQ || state == S_RESP);
    bus_valid = state == S_REQ;
    ld_valid = state == S_DONE && !we_r && !to_r;
    exc_valid = reset && ((state == S_IDLE && mem_req && mis) || (state == S_DONE && to_r));
    exc_code = !exc_valid ? 5'd0 : (state == S_IDLE ? mem_we : we_r) ? EXC_ADES : EXC_ADEL;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= S_IDLE;
      cnt <= '0;
      we_r <= 1'b0;
      to_r <= 1'b0;
      addr_r <= '0;
      op_r <= '0;
      bus_addr <= '0;
      bus_byteen <= '0;
      bus_wdata <= '0;
      ld_data <= '0;
      ld_addr <= '0;
      ld_byteop <= '0;
    end else begin
      state <= nxt;
      cnt <= (state == S_REQ || state == S_RESP) ? cnt + 16'd1 : '0;
      to_r <= tmo;
      if (go) begin
        we_r <= mem_we;
        addr_r <= mem_addr;
        op_r <= ByteOp;
        bus_addr <= {mem_addr[31:2], 2'b00};
        bus_byteen <= mem_we ? be : 4'b0000;
        bus_wdata <= mem_we ? wl : '0;
      end
      // extender-facing fields change only when a load actually completes
      if (cap) begin
        ld_data <= bus_rdata;
        ld_addr <= addr_r;
        ld_byteop <= op_r;
      end
    end
endmodule

// File: tb/tb_mem_bus_lsu.sv
// tb_mem_bus_lsu: table-driven and directed checks of mem_bus_lsu (TIMEOUT=4)
module tb_mem_bus_lsu;
  logic clk = 0, reset = 0, mem_req = 0, mem_we = 0, bus_ready = 0, bus_rvalid = 0;
  logic [31:0] mem_addr = 0, mem_wdata = 0, bus_rdata = 0;
  logic [2:0] ByteOp = 0;
  logic stall, exc_valid, bus_valid, ld_valid;
  logic [4:0] exc_code;
  logic [31:0] bus_addr, bus_wdata, ld_data, ld_addr;
  logic [3:0] bus_byteen;
  logic [2:0] ld_byteop;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  mem_bus_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .ByteOp(ByteOp), .stall(stall), .exc_valid(exc_valid),
    .exc_code(exc_code), .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
    .bus_byteen(bus_byteen), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .ld_valid(ld_valid), .ld_data(ld_data), .ld_addr(ld_addr),
    .ld_byteop(ld_byteop)
  );
  typedef struct {
    logic we; logic [2:0] op; logic [31:0] addr, wdata; logic [3:0] be; logic [31:0] wl; logic mis;
  } vec_t;
  vec_t v [12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic cyc;
    @(negedge clk);
  endtask
  task automatic count_stall(output int n);
    n = 0;
    while (stall && n < 20) begin
      n++;
      cyc;
      #1;
    end
  endtask
  function automatic logic [31:0] ext(input logic [31:0] d, input logic [31:0] a, input logic [2:0] op);
    logic [31:0] s;
    s = d >> {a[1:0], 3'b000};
    return op == 3'b101 ? {{24{s[7]}}, s[7:0]} : op == 3'b110 ? {{16{s[15]}}, s[15:0]} : d;
  endfunction
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, nv;
    v[0]  = '{0, 3'b000, 32'h0000_0100, 32'h0,         4'h0, 32'h0,         0};
    v[1]  = '{1, 3'b000, 32'h0000_0104, 32'h1234_5678, 4'hF, 32'h1234_5678, 0};
    v[2]  = '{1, 3'b101, 32'h0000_0201, 32'hFFFF_FF5A, 4'h2, 32'h5A5A_5A5A, 0};
    v[3]  = '{1, 3'b101, 32'h0000_0202, 32'h0000_0077, 4'h4, 32'h7777_7777, 0};
    v[4]  = '{1, 3'b110, 32'h0000_0302, 32'hAAAA_BEEF, 4'hC, 32'hBEEF_BEEF, 0};
    v[5]  = '{1, 3'b110, 32'h0000_0300, 32'h0000_1357, 4'h3, 32'h1357_1357, 0};
    v[6]  = '{1, 3'b011, 32'h0000_0408, 32'hCAFE_F00D, 4'hF, 32'hCAFE_F00D, 0};
    v[7]  = '{0, 3'b101, 32'h0000_0003, 32'h0,         4'h0, 32'h0,         0};
    v[8]  = '{0, 3'b000, 32'h0000_3001, 32'h0,         4'h0, 32'h0,         1};
    v[9]  = '{1, 3'b110, 32'h0000_3003, 32'h0,         4'h0, 32'h0,         1};
    v[10] = '{0, 3'b110, 32'h0000_2001, 32'h0,         4'h0, 32'h0,         1};
    v[11] = '{1, 3'b111, 32'h0000_0402, 32'h0,         4'h0, 32'h0,         1};
    repeat (2) cyc;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_ld_data", ld_data, 0);
    chk("rst_exc_valid", exc_valid, 0);
    reset = 1;
    cyc;
    #1;
    chk("idle_noreq_stall", stall, 0);
    foreach (v[i]) begin
      cyc;
      mem_req = 1; mem_we = v[i].we; ByteOp = v[i].op; mem_addr = v[i].addr; mem_wdata = v[i].wdata;
      #1;
      chk($sformatf("v%0d_exc_valid", i), exc_valid, v[i].mis);
      chk($sformatf("v%0d_stall", i), stall, !v[i].mis);
      if (v[i].mis) chk($sformatf("v%0d_exc_code", i), exc_code, v[i].we ? 5 : 4);
      else begin
        cyc;
        #1;
        chk($sformatf("v%0d_bus_valid", i), bus_valid, 1);
        chk($sformatf("v%0d_bus_addr", i), bus_addr, {v[i].addr[31:2], 2'b00});
        chk($sformatf("v%0d_byteen", i), bus_byteen, v[i].we ? v[i].be : 4'h0);
        if (v[i].we) chk($sformatf("v%0d_wdata", i), bus_wdata, v[i].wl);
        bus_ready = 1; bus_rvalid = 1; bus_rdata = 32'h5A00_0000 ^ v[i].addr;
        cyc;
        bus_ready = 0; bus_rvalid = 0;
        #1;
        chk($sformatf("v%0d_done_stall", i), stall, 0);
        chk($sformatf("v%0d_ld_valid", i), ld_valid, !v[i].we);
        if (!v[i].we) begin
          chk($sformatf("v%0d_ld_data", i), ld_data, 32'h5A00_0000 ^ v[i].addr);
          chk($sformatf("v%0d_ld_addr", i), ld_addr, v[i].addr);
          chk($sformatf("v%0d_ld_byteop", i), ld_byteop, v[i].op);
        end
      end
      cyc;
      mem_req = 0;
      #1;
      chk($sformatf("v%0d_after_bus_valid", i), bus_valid, 0);
    end
    // sb with ready on the second REQ cycle
    cyc;
    mem_req = 1; mem_we = 1; ByteOp = 3'b101; mem_addr = 32'h1003; mem_wdata = 32'hAB;
    #1;
    n = int'(stall);
    cyc;
    #1;
    chk("sb_bus_addr", bus_addr, 32'h1000);
    chk("sb_byteen", bus_byteen, 4'b1000);
    chk("sb_wdata", bus_wdata, 32'hABAB_ABAB);
    n += int'(stall);
    cyc;
    bus_ready = 1;
    #1;
    chk("sb_hold_valid", bus_valid, 1);
    n += int'(stall);
    cyc;
    bus_ready = 0;
    #1;
    n += int'(stall);
    chk("sb_stall_cycles", n, 3);
    chk("sb_ld_valid", ld_valid, 0);
    chk("sb_valid_dropped", bus_valid, 0);
    cyc;
    mem_req = 0;
    // lh with rvalid two cycles after acceptance
    cyc;
    mem_req = 1; mem_we = 0; ByteOp = 3'b110; mem_addr = 32'h2002;
    cyc;
    bus_ready = 1;
    #1;
    chk("lh_byteen", bus_byteen, 0);
    chk("lh_bus_valid", bus_valid, 1);
    cyc;
    bus_ready = 0;
    #1;
    chk("lh_resp_valid", bus_valid, 0);
    chk("lh_resp_stall", stall, 1);
    cyc;
    bus_rvalid = 1; bus_rdata = 32'h8001_1234;
    cyc;
    bus_rvalid = 0;
    #1;
    chk("lh_ld_valid", ld_valid, 1);
    chk("lh_ld_data", ld_data, 32'h8001_1234);
    chk("lh_ld_addr", ld_addr, 32'h2002);
    chk("lh_ld_byteop", ld_byteop, 3'b110);
    chk("lh_extended", ext(ld_data, ld_addr, ld_byteop), 32'hFFFF_8001);
    chk("lh_done_stall", stall, 0);
    cyc;
    mem_req = 0;
    #1;
    chk("lh_ld_pulse", ld_valid, 0);
    // lw with ready and rvalid in the first REQ cycle
    cyc;
    mem_req = 1; mem_we = 0; ByteOp = 3'b000; mem_addr = 32'h3008;
    bus_ready = 1; bus_rvalid = 1; bus_rdata = 32'hDEAD_BEEF;
    #1;
    count_stall(n);
    chk("lw_fast_stall_cycles", n, 2);
    chk("lw_fast_ld_valid", ld_valid, 1);
    chk("lw_fast_ld_data", ld_data, 32'hDEAD_BEEF);
    bus_ready = 0; bus_rvalid = 0;
    cyc;
    mem_req = 0;
    // load timeout with bus_ready held low
    cyc;
    mem_req = 1; mem_we = 0; ByteOp = 3'b000; mem_addr = 32'h4000;
    #1;
    n = 0; nv = 0;
    for (int k = 0; k < 5; k++) begin
      n += int'(stall);
      nv += int'(bus_valid);
      cyc;
      #1;
    end
    chk("to_stall_cycles", n, 5);
    chk("to_valid_cycles", nv, 4);
    chk("to_exc_valid", exc_valid, 1);
    chk("to_exc_code", exc_code, 4);
    chk("to_bus_valid", bus_valid, 0);
    chk("to_ld_valid", ld_valid, 0);
    cyc;
    mem_req = 0; bus_rvalid = 1; bus_rdata = 32'h1111_1111;
    #1;
    chk("to_exc_pulse", exc_valid, 0);
    cyc;
    bus_rvalid = 0;
    #1;
    chk("to_stray_ld_valid", ld_valid, 0);
    chk("to_stray_ld_data", ld_data, 32'hDEAD_BEEF);
    chk("to_idle_stall", stall, 0);
    // store timeout reports the store code
    cyc;
    mem_req = 1; mem_we = 1; mem_addr = 32'h4004;
    repeat (5) cyc;
    #1;
    chk("sto_exc_valid", exc_valid, 1);
    chk("sto_exc_code", exc_code, 5);
    cyc;
    mem_req = 0;
    // reset asserted while waiting in RESP
    cyc;
    mem_req = 1; mem_we = 0; ByteOp = 3'b000; mem_addr = 32'h5000;
    cyc;
    bus_ready = 1;
    cyc;
    bus_ready = 0;
    #1;
    chk("rr_resp_stall", stall, 1);
    #1 reset = 0;
    #1;
    chk("rr_stall", stall, 0);
    chk("rr_bus_valid", bus_valid, 0);
    chk("rr_bus_addr", bus_addr, 0);
    chk("rr_ld_data", ld_data, 0);
    chk("rr_ld_addr", ld_addr, 0);
    chk("rr_exc_valid", exc_valid, 0);
    cyc;
    mem_req = 0; reset = 1;
    cyc;
    mem_req = 1; mem_addr = 32'h6004; bus_ready = 1; bus_rvalid = 1; bus_rdata = 32'h0BAD_F00D;
    #1;
    count_stall(n);
    chk("rr_new_stall_cycles", n, 2);
    chk("rr_new_ld_valid", ld_valid, 1);
    chk("rr_new_ld_data", ld_data, 32'h0BAD_F00D);
    chk("rr_new_ld_addr", ld_addr, 32'h6004);
    mem_req = 0; bus_ready = 0; bus_rvalid = 0;
    cyc;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
